// File: rtl/writeback_unit.sv
// Writeback queue in front of the register-file write port: two valid/ready sources, in-order
// drain of one write per cycle, pending-write mask. Optional forwarding port under WB_FORWARD_EN.
module writeback_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  output logic                     reg_write,
  output logic [4:0]               write_reg,
  output logic [XLEN-1:0]          write_data,
  output logic [31:0]              pending,
`ifdef WB_FORWARD_EN
  input  logic [4:0]               fwd_addr,
  output logic                     fwd_hit,
  output logic [XLEN-1:0]          fwd_data,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q, tail_d, alu_slot;
  logic [CW-1:0]   count_q, count_d;
  logic            reg_write_q;
  logic [4:0]      write_reg_q;
  logic [XLEN-1:0] write_data_q;

  logic            mem_push, alu_push, pop;
  logic [DEPTH-1:0] entry_vld;

  // Readiness uses pre-edge occupancy only; a same-edge pop is not credited.
  always_comb begin
    mem_ready = reset && (count_q < CW'(DEPTH));
    alu_ready = reset && ((count_q < CW'(DEPTH - 1)) || ((count_q < CW'(DEPTH)) && !mem_valid));
  end

  always_comb begin
    mem_push = mem_valid && mem_ready && (mem_rd != 5'd0);
    alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    pop      = (count_q != '0);
    alu_slot = tail_q + PW'(mem_push);
    tail_d   = tail_q + PW'(mem_push) + PW'(alu_push);
    count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  // Mem is enqueued ahead of alu when both push on one edge.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      rd_q[tail_q]   <= mem_rd;
      data_q[tail_q] <= mem_data;
    end
    if (alu_push) begin
      rd_q[alu_slot]   <= alu_rd;
      data_q[alu_slot] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= '0;
    end else begin
      head_q      <= head_q + PW'(pop);
      tail_q      <= tail_d;
      count_q     <= count_d;
      reg_write_q <= pop;
      if (pop) begin
        write_reg_q  <= rd_q[head_q];
        write_data_q <= data_q[head_q];
      end
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    entry_vld = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_vld[i] = ({1'b0, PW'(i) - head_q} < count_q);
    end
  end

  always_comb begin
    pending = '0;
    if (reg_write_q) pending[write_reg_q] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) pending[rd_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign count      = count_q;

`ifdef WB_FORWARD_EN
  logic [PW-1:0] fwd_idx;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit  = pending[fwd_addr];
    fwd_data = '0;
    fwd_idx  = '0;
    if (reg_write_q && (write_reg_q == fwd_addr)) fwd_data = write_data_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if (({1'b0, PW'(k)} < count_q) && (rd_q[fwd_idx] == fwd_addr)) fwd_data = data_q[fwd_idx];
    end
    if (!fwd_hit) fwd_data = '0;
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized bench for writeback_unit against a queue-based reference model.
module tb_writeback_unit;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]            alu_rd, mem_rd;
  logic [XLEN-1:0]       alu_data, mem_data;
  logic                  reg_write;
  logic [4:0]            write_reg;
  logic [XLEN-1:0]       write_data;
  logic [31:0]           pending;
  logic [$clog2(DEPTH):0] count;
`ifdef WB_FORWARD_EN
  logic [4:0]            fwd_addr;
  logic                  fwd_hit;
  logic [XLEN-1:0]       fwd_data;
  int                    fwd_fix = -1;
`endif

  writeback_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .pending   (pending),
`ifdef WB_FORWARD_EN
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents plus the output stage.
  ent_t            mq[$];
  logic            m_rw;
  logic [4:0]      m_wr;
  logic [XLEN-1:0] m_wd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (mq[i]) p[mq[i].rd] = 1'b1;
    if (m_rw) p[m_wr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic offer_alu(input logic [4:0] rd, input logic [XLEN-1:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
  endtask

  task automatic offer_mem(input logic [4:0] rd, input logic [XLEN-1:0] d);
    mem_valid = 1'b1; mem_rd = rd; mem_data = d;
  endtask

  function automatic logic [4:0] rand_rd();
    return ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
  endfunction

  task automatic check_outputs();
    check_eq("count", 64'(count), 64'(mq.size()));
    check_eq("reg_write", 64'(reg_write), 64'(m_rw));
    check_eq("write_reg", 64'(write_reg), 64'(m_wr));
    check_eq("write_data", write_data, m_wd);
    check_eq("pending", 64'(pending), 64'(model_pending()));
  endtask

`ifdef WB_FORWARD_EN
  task automatic check_fwd();
    logic [31:0]     p;
    logic [XLEN-1:0] d = '0;
    logic            found = 1'b0;
    p = model_pending();
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!found && mq[i].rd == fwd_addr) begin d = mq[i].data; found = 1'b1; end
    end
    if (!found && m_rw && m_wr == fwd_addr) d = m_wd;
    if (!p[fwd_addr]) d = '0;
    check_eq("fwd_hit", 64'(fwd_hit), 64'(p[fwd_addr]));
    check_eq("fwd_data", fwd_data, d);
  endtask
`endif

  // One clock with reset high; called just after a falling edge.
  task automatic run_cycle();
    logic exp_mr, exp_ar, mx, ax;
    ent_t e;
    exp_mr = (mq.size() < DEPTH);
    exp_ar = (mq.size() < DEPTH - 1) || ((mq.size() < DEPTH) && !mem_valid);
`ifdef WB_FORWARD_EN
    fwd_addr = (fwd_fix >= 0) ? 5'(fwd_fix) : 5'($urandom_range(31));
`endif
    #1;
    check_eq("mem_ready", 64'(mem_ready), 64'(exp_mr));
    check_eq("alu_ready", 64'(alu_ready), 64'(exp_ar));
`ifdef WB_FORWARD_EN
    check_fwd();
`endif
    mx = mem_valid && exp_mr;
    ax = alu_valid && exp_ar;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_rw = 1'b1; m_wr = e.rd; m_wd = e.data;
    end else begin
      m_rw = 1'b0;
    end
    if (mx && mem_rd != 5'd0) mq.push_back({mem_rd, mem_data});
    if (ax && alu_rd != 5'd0) mq.push_back({alu_rd, alu_data});
    @(posedge clk);
    #1;
    if (mx) mem_valid = 1'b0;
    if (ax) alu_valid = 1'b0;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset(input int edges);
    reset = 1'b0;
    for (int i = 0; i < edges; i++) begin
      #1;
      check_eq("rst_mem_ready", 64'(mem_ready), 64'd0);
      check_eq("rst_alu_ready", 64'(alu_ready), 64'd0);
      mq.delete();
      m_rw = 1'b0; m_wr = 5'd0; m_wd = '0;
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
    end
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic random_run(input int cycles, input int pm, input int pa);
    for (int c = 0; c < cycles; c++) begin
      if (!mem_valid && $urandom_range(99) < pm) offer_mem(rand_rd(), {$urandom, $urandom});
      if (!alu_valid && $urandom_range(99) < pa) offer_alu(rand_rd(), {$urandom, $urandom});
      run_cycle();
    end
  endtask

  initial begin
    reset = 1'b0;
    offer_mem(5'd3, 64'h1);
    offer_alu(5'd4, 64'h2);
    m_rw = 1'b0; m_wr = 5'd0; m_wd = '0;
    @(negedge clk);
    do_reset(2);

    // Single ALU write to x5.
    offer_alu(5'd5, 64'hDEAD_BEEF_CAFE_BABE);
    run_cycle();
    check_eq("x5_pending_after_n", 64'(pending[5]), 64'd1);
    run_cycle();
    check_eq("x5_present", 64'({reg_write, write_reg}), 64'({1'b1, 5'd5}));
    run_cycle();
    check_eq("x5_pending_cleared", 64'(pending[5]), 64'd0);

    // Same-edge mem/alu: mem first.
    offer_mem(5'd10, 64'h1234_5678_9ABC_DEF0);
    offer_alu(5'd11, 64'h1);
    repeat (4) run_cycle();

    // x0 filtered.
    offer_alu(5'd0, 64'hFEDC_BA98_7654_3210);
    repeat (3) run_cycle();

`ifdef WB_FORWARD_EN
    fwd_fix = 7;
    offer_alu(5'd7, 64'hA);
    offer_mem(5'd9, 64'h99);
    run_cycle();
    offer_alu(5'd7, 64'hB);
    run_cycle();
    check_eq("fwd_x7_data", fwd_data, 64'hB);
    repeat (3) run_cycle();
    fwd_fix = -1;
`endif

    // Saturating dual-source input, then reset with entries queued.
    random_run(30, 100, 100);
    do_reset(1);
    repeat (3) run_cycle();

    for (int ph = 0; ph < 8; ph++) begin
      random_run(60, $urandom_range(100), $urandom_range(100));
      if (ph == 4) do_reset(1);
    end
    random_run(10, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
